frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
- Frame-granular arbiter that shares the single grayscale→gaussian→sobel pipeline between two RGB pixel sources.
- Grants one source for one whole frame (IMG_WIDTH*IMG_HEIGHT pixels) and forwards its pixels into the pipeline input FIFO.
- Records grant order in an internal tag queue and steers each returning sobel frame to the matching sink FIFO.
- Sits between the source/sink FIFOs and dut_system's fifo_rgb / fifo_sobel ports.

Parameters:
- IMG_WIDTH, 720, pixels per row.
- IMG_HEIGHT, 540, rows per frame.
- RGB_DWIDTH, 24, source/pipeline input pixel width.
- SOBEL_DWIDTH, 8, pipeline output/sink pixel width.
- TAG_DEPTH, 4, maximum frames in flight (power of 2, ≥2).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  1 = new frame grants allowed; a frame in progress always completes
- src0_dout  in  RGB_DWIDTH  source 0 show-ahead FIFO data
- src0_empty  in  1  source 0 empty
- src0_rd_en  out  1  source 0 pop
- src1_dout  in  RGB_DWIDTH  source 1 data
- src1_empty  in  1  source 1 empty
- src1_rd_en  out  1  source 1 pop
- pipe_din  out  RGB_DWIDTH  to fifo_rgb_din
- pipe_full  in  1  from fifo_rgb_full
- pipe_wr_en  out  1  to fifo_rgb_wr_en
- pipe_dout  in  SOBEL_DWIDTH  from fifo_sobel_dout
- pipe_empty  in  1  from fifo_sobel_empty
- pipe_rd_en  out  1  to fifo_sobel_rd_en
- snk0_din  out  SOBEL_DWIDTH  sink 0 data
- snk0_full  in  1  sink 0 full
- snk0_wr_en  out  1  sink 0 push
- snk1_din  out  SOBEL_DWIDTH  sink 1 data
- snk1_full  in  1  sink 1 full
- snk1_wr_en  out  1  sink 1 push
- frame_done  out  1  one-cycle pulse when the last output pixel of a frame is written to a sink
- frame_done_src  out  1  source index of that frame, valid with frame_done
- busy  out  1  1 when feed FSM is not IDLE or the tag queue is non-empty

Behaviour:
- Reset (reset=0, async): feed FSM→IDLE, drain FSM→IDLE, all counters 0, tag queue empty, last_grant=1, all rd_en/wr_en/frame_done/busy = 0, data outputs 0. Applies at any time, including mid-frame; partial frames are discarded, no recovery.
- FIFOs are show-ahead: dout is valid while empty=0; a pop happens on the rising edge where rd_en=1.
- Feed FSM, state IDLE:
  - A request is src_k_empty=0.
  - If enable=1, any request, and registered tag_count<TAG_DEPTH: grant round-robin (both requesting → the source ≠ last_grant; one requesting → that source).
  - On grant: register grant and last_grant, push grant into the tag queue, clear in_count, go to FEED.
  - No outputs asserted in IDLE, so there is one bubble cycle between frames.
- Feed FSM, state FEED (combinational xfer = !src_g_empty && !pipe_full):
  - src_g_rd_en = pipe_wr_en = xfer; pipe_din = src_g_dout.
  - The ungranted source rd_en is 0.
  - in_count increments per xfer; the xfer at in_count=IMG_WIDTH*IMG_HEIGHT-1 returns to IDLE.
  - Stalls of any length are legal.
  - enable deassert in FEED has no effect.
- Drain FSM (tag queue head h, combinational dxfer = tag_count>0 && !pipe_empty && !snk_h_full):
  - pipe_rd_en = snk_h_wr_en = dxfer; snk_h_din = pipe_dout; the other sink wr_en is 0.
  - out_count increments per dxfer.
  - The dxfer at out_count=IMG_WIDTH*IMG_HEIGHT-1 pops the tag, clears out_count, and pulses frame_done with frame_done_src=h on the following cycle (registered).
  - tag_count=0 → pipe_rd_en=0 even if pipe_empty=0.
- Tag queue:
  - Push and pop in the same cycle leave tag_count unchanged.
  - Grant eligibility uses the registered tag_count only; no same-cycle bypass of a pop.
- Counters are $clog2(IMG_WIDTH*IMG_HEIGHT) bits wide and never wrap past the frame size.

Optional Feature:
- Macro FRAME_SCHED_STATS_EN.
- When defined:
  - Adds outputs frames0_cnt [15:0] and frames1_cnt [15:0], each incremented on frame_done for its source and wrapping at 16'hFFFF→0.
  - Adds stall_cnt [31:0], incremented each cycle the feed FSM is in FEED with xfer=0, saturating at 32'hFFFFFFFF.
  - All three counters reset to 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- IMG 4x2, src0 holds 8 pixels, src1 empty, pipe model = delay FIFO → 8 writes to pipe, src0_rd_en high 8 cycles, snk0 receives 8 pixels in order, frame_done=1 with frame_done_src=0 once, snk1_wr_en never 1.
- Both sources hold 16 pixels from reset → grant order 0,1,0,1; one idle cycle between frames; sinks each receive 16 pixels with no cross-steering.
- TAG_DEPTH=2, pipeline output held empty → after 2 frames are fed, grant stalls with tag_count=2; releasing pipe_empty lets frame 3 start only after the first frame_done.
- Random pipe_full, snk0_full and src empty toggling (30%) → pixel data bit-exact, no rd_en while empty, no wr_en while full.
- reset=0 asserted mid-FEED (in_count=3) → all outputs 0 asynchronously, busy=0; after release the next grant goes to src0.
- enable=0 with src1 non-empty → no grant for 20 cycles; enable=1 → FEED entered on the next cycle. With STATS_EN, stall_cnt equals the counted stall cycles.

Source files
------------

// File: rtl/frame_scheduler.sv
// Frame-granular round-robin arbiter sharing one image pipeline between two sources.
// Optional statistics counters are enabled with `define FRAME_SCHED_STATS_EN.
module frame_scheduler #(
  parameter int IMG_WIDTH    = 720,
  parameter int IMG_HEIGHT   = 540,
  parameter int RGB_DWIDTH   = 24,
  parameter int SOBEL_DWIDTH = 8,
  parameter int TAG_DEPTH    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [RGB_DWIDTH-1:0]   src0_dout,
  input  logic                    src0_empty,
  output logic                    src0_rd_en,
  input  logic [RGB_DWIDTH-1:0]   src1_dout,
  input  logic                    src1_empty,
  output logic                    src1_rd_en,
  output logic [RGB_DWIDTH-1:0]   pipe_din,
  input  logic                    pipe_full,
  output logic                    pipe_wr_en,
  input  logic [SOBEL_DWIDTH-1:0] pipe_dout,
  input  logic                    pipe_empty,
  output logic                    pipe_rd_en,
  output logic [SOBEL_DWIDTH-1:0] snk0_din,
  input  logic                    snk0_full,
  output logic                    snk0_wr_en,
  output logic [SOBEL_DWIDTH-1:0] snk1_din,
  input  logic                    snk1_full,
  output logic                    snk1_wr_en,
  output logic                    frame_done,
  output logic                    frame_done_src,
`ifdef FRAME_SCHED_STATS_EN
  output logic [15:0]             frames0_cnt,
  output logic [15:0]             frames1_cnt,
  output logic [31:0]             stall_cnt,
`endif
  output logic                    busy
);

  localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW        = $clog2(FRAME_PIX);
  localparam int PW        = $clog2(TAG_DEPTH);
  localparam int QW        = PW + 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(FRAME_PIX - 1);
  localparam logic [QW-1:0] TAG_FULL = QW'(TAG_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, FEED = 1'b1} feed_state_t;

  feed_state_t   state;
  feed_state_t   state_next;
  logic          grant;
  logic          grant_next;
  logic          grant_take;
  logic          last_grant;
  logic [CW-1:0] in_count;
  logic          xfer;

  logic          tag_mem [TAG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [QW-1:0] tag_count;
  logic          head;
  logic          dxfer;
  logic          frame_end;
  logic [CW-1:0] out_count;

  // Feed FSM: grant selection in IDLE, pixel forwarding in FEED
  always_comb begin
    state_next = state;
    grant_next = grant;
    grant_take = 1'b0;
    xfer       = 1'b0;
    src0_rd_en = 1'b0;
    src1_rd_en = 1'b0;
    pipe_wr_en = 1'b0;
    pipe_din   = '0;
    case (state)
      IDLE: begin
        if (enable && (!src0_empty || !src1_empty) && (tag_count < TAG_FULL)) begin
          grant_take = 1'b1;
          grant_next = (!src0_empty && !src1_empty) ? ~last_grant : !src1_empty;
          state_next = FEED;
        end else begin
          state_next = IDLE;
        end
      end
      FEED: begin
        xfer       = (grant ? !src1_empty : !src0_empty) && !pipe_full;
        pipe_wr_en = xfer;
        pipe_din   = grant ? src1_dout : src0_dout;
        src0_rd_en = xfer && !grant;
        src1_rd_en = xfer && grant;
        if (xfer && (in_count == LAST_PIX)) begin
          state_next = IDLE;
        end else begin
          state_next = FEED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Feed FSM state, grant history and input pixel counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      in_count   <= '0;
    end else begin
      state <= state_next;
      if (grant_take) begin
        grant      <= grant_next;
        last_grant <= grant_next;
        in_count   <= '0;
      end else if (xfer) begin
        in_count <= (in_count == LAST_PIX) ? '0 : in_count + CW'(1);
      end
    end
  end

  // Drain path: the oldest outstanding tag steers pipeline output to its sink
  always_comb begin
    head       = tag_mem[rd_ptr];
    dxfer      = (tag_count != '0) && !pipe_empty && !(head ? snk1_full : snk0_full);
    pipe_rd_en = dxfer;
    snk0_wr_en = dxfer && !head;
    snk1_wr_en = dxfer && head;
    snk0_din   = ((tag_count != '0) && !head) ? pipe_dout : '0;
    snk1_din   = ((tag_count != '0) && head) ? pipe_dout : '0;
    frame_end  = dxfer && (out_count == LAST_PIX);
  end

  // Tag queue: push on grant, pop when a frame's last pixel reaches its sink
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem[i] <= 1'b0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tag_count <= '0;
    end else begin
      if (grant_take) begin
        tag_mem[wr_ptr] <= grant_next;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (frame_end) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({grant_take, frame_end})
        2'b10:   tag_count <= tag_count + QW'(1);
        2'b01:   tag_count <= tag_count - QW'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Output pixel counter and registered end-of-frame pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_count      <= '0;
      frame_done     <= 1'b0;
      frame_done_src <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        out_count      <= '0;
        frame_done_src <= head;
      end else if (dxfer) begin
        out_count <= out_count + CW'(1);
      end
    end
  end

  assign busy = (state != IDLE) || (tag_count != '0);

`ifdef FRAME_SCHED_STATS_EN
  // Per-source frame counters (wrapping) and feed stall counter (saturating)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frames0_cnt <= 16'd0;
      frames1_cnt <= 16'd0;
      stall_cnt   <= 32'd0;
    end else begin
      if (frame_done && frame_done_src) begin
        frames1_cnt <= frames1_cnt + 16'd1;
      end else if (frame_done) begin
        frames0_cnt <= frames0_cnt + 16'd1;
      end
      if ((state == FEED) && !xfer && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler with a 4x2 frame and two tags; models source, pipeline and sink FIFOs.
module tb_frame_scheduler;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [23:0] src0_dout, src1_dout, pipe_din;
  logic        src0_empty, src1_empty, src0_rd_en, src1_rd_en;
  logic        pipe_full, pipe_wr_en, pipe_empty, pipe_rd_en;
  logic [7:0]  pipe_dout, snk0_din, snk1_din;
  logic        snk0_full, snk0_wr_en, snk1_full, snk1_wr_en;
  logic        frame_done, frame_done_src, busy;
`ifdef FRAME_SCHED_STATS_EN
  logic [15:0] frames0_cnt, frames1_cnt;
  logic [31:0] stall_cnt;
`endif

  frame_scheduler #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .RGB_DWIDTH(24), .SOBEL_DWIDTH(8), .TAG_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .src0_dout(src0_dout), .src0_empty(src0_empty), .src0_rd_en(src0_rd_en),
    .src1_dout(src1_dout), .src1_empty(src1_empty), .src1_rd_en(src1_rd_en),
    .pipe_din(pipe_din), .pipe_full(pipe_full), .pipe_wr_en(pipe_wr_en),
    .pipe_dout(pipe_dout), .pipe_empty(pipe_empty), .pipe_rd_en(pipe_rd_en),
    .snk0_din(snk0_din), .snk0_full(snk0_full), .snk0_wr_en(snk0_wr_en),
    .snk1_din(snk1_din), .snk1_full(snk1_full), .snk1_wr_en(snk1_wr_en),
    .frame_done(frame_done), .frame_done_src(frame_done_src),
`ifdef FRAME_SCHED_STATS_EN
    .frames0_cnt(frames0_cnt), .frames1_cnt(frames1_cnt), .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  logic [23:0] s0q[$], s1q[$];
  logic [7:0]  pq[$], k0q[$], k1q[$], e0q[$], e1q[$];
  logic        fdq[$];
  bit          rnd, hold_pipe, force_full, released;
  int          cyc, rd0_cnt, rd1_cnt, wr_cnt, w1_cnt, first_x, last_x, fd_first, rd_after;
  logic        r0, r1, pwr, prd, w0, w1;
  logic [23:0] pdin;
  logic [7:0]  d0, d1;

  typedef struct {
    logic en, e0, e1, full;
    logic busy, rd0, rd1, wr;
    logic [23:0] din;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    s0q.delete(); s1q.delete(); pq.delete(); k0q.delete(); k1q.delete();
    e0q.delete(); e1q.delete(); fdq.delete();
    rnd = 0; hold_pipe = 0; force_full = 0; released = 0;
    cyc = 0; rd0_cnt = 0; rd1_cnt = 0; wr_cnt = 0; w1_cnt = 0;
    first_x = -1; last_x = -1; fd_first = -1; rd_after = -1;
    r0 = 0; r1 = 0;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; src0_dout = '0; src1_dout = '0; src0_empty = 1'b1; src1_empty = 1'b1;
    pipe_full = 1'b0; pipe_dout = '0; pipe_empty = 1'b1; snk0_full = 1'b0; snk1_full = 1'b0;
  endtask

  // Called at a negative edge; leaves the bench at a negative edge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    clear_model();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic load(input int src, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = base + 8'(i);
      if (src == 0) begin s0q.push_back({8'h5A, 8'h00, b}); e0q.push_back(b); end
      else          begin s1q.push_back({8'hA5, 8'h11, b}); e1q.push_back(b); end
    end
  endtask

  task automatic drive_inputs();
    bit m0, m1;
    m0 = rnd && ($urandom_range(0, 9) < 3);
    m1 = rnd && ($urandom_range(0, 9) < 3);
    src0_empty = (s0q.size() == 0) || m0;
    src0_dout  = (s0q.size() != 0) ? s0q[0] : 24'h0;
    src1_empty = (s1q.size() == 0) || m1;
    src1_dout  = (s1q.size() != 0) ? s1q[0] : 24'h0;
    pipe_full  = force_full || (rnd && ($urandom_range(0, 9) < 3));
    pipe_empty = (pq.size() == 0) || hold_pipe;
    pipe_dout  = (pq.size() != 0) ? pq[0] : 8'h0;
    snk0_full  = rnd && ($urandom_range(0, 9) < 3);
    snk1_full  = rnd && ($urandom_range(0, 9) < 3);
  endtask

  // One clock of the FIFO models: drive at negedge, sample, apply effects after posedge.
  task automatic cycle();
    drive_inputs();
    #1;
    chk("rd0_while_empty", src0_rd_en & src0_empty, 1'b0);
    chk("rd1_while_empty", src1_rd_en & src1_empty, 1'b0);
    chk("pipe_wr_while_full", pipe_wr_en & pipe_full, 1'b0);
    chk("pipe_rd_while_empty", pipe_rd_en & pipe_empty, 1'b0);
    chk("snk0_wr_while_full", snk0_wr_en & snk0_full, 1'b0);
    chk("snk1_wr_while_full", snk1_wr_en & snk1_full, 1'b0);
    r0 = src0_rd_en; r1 = src1_rd_en; pwr = pipe_wr_en; pdin = pipe_din; prd = pipe_rd_en;
    w0 = snk0_wr_en; d0 = snk0_din; w1 = snk1_wr_en; d1 = snk1_din;
    if (pwr || r0 || r1) chk("wr_matches_rd", {30'd0, r1, r0}, pwr ? {30'd0, src1_rd_en, !src1_rd_en} : 32'd0);
    if (pwr && r0 && s0q.size() != 0) chk("pipe_din0", pdin, s0q[0]);
    if (pwr && r1 && s1q.size() != 0) chk("pipe_din1", pdin, s1q[0]);
    if (frame_done) begin
      fdq.push_back(frame_done_src);
      if (fd_first < 0) fd_first = cyc;
    end
    if (r0) rd0_cnt++;
    if (r1) rd1_cnt++;
    if (pwr) wr_cnt++;
    if (w1) w1_cnt++;
    if (r0 || r1) begin
      if (first_x < 0) first_x = cyc;
      last_x = cyc;
      if (released && rd_after < 0) rd_after = cyc;
    end
    @(posedge clock);
    #1;
    if (r0 && s0q.size() != 0) void'(s0q.pop_front());
    if (r1 && s1q.size() != 0) void'(s1q.pop_front());
    if (prd && pq.size() != 0) void'(pq.pop_front());
    if (pwr) pq.push_back(pdin[7:0]);
    if (w0) k0q.push_back(d0);
    if (w1) k1q.push_back(d1);
    cyc++;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_fd(input int n, input int budget);
    int i;
    i = 0;
    while (fdq.size() < n && i < budget) begin
      cycle();
      i++;
    end
    chk("frame_done_count", fdq.size(), n);
  endtask

  task automatic cmp_sinks();
    chk("snk0_len", k0q.size(), e0q.size());
    chk("snk1_len", k1q.size(), e1q.size());
    for (int i = 0; i < k0q.size() && i < e0q.size(); i++) chk("snk0_data", k0q[i], e0q[i]);
    for (int i = 0; i < k1q.size() && i < e1q.size(); i++) chk("snk1_data", k1q[i], e1q[i]);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24'hA1B2C3};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h445566};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24'hA1B2C3};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'hA1B2C3};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};

    // Reset state with live inputs
    reset = 1'b1;
    idle_inputs();
    clear_model();
    src0_empty = 1'b0; src1_empty = 1'b0; pipe_empty = 1'b0;
    src0_dout = 24'h123456; src1_dout = 24'h654321; pipe_dout = 8'h77;
    #1 reset = 1'b0;
    #1;
    chk("reset_ctrl", {src0_rd_en, src1_rd_en, pipe_wr_en, pipe_rd_en, snk0_wr_en, snk1_wr_en, frame_done, busy}, 8'h00);
    chk("reset_data", {pipe_din, snk0_din, snk1_din}, 32'h0);
    @(negedge clock);
    do_reset();

    // Single-cycle grant decisions after reset
    for (int v = 0; v < 7; v++) begin
      do_reset();
      enable = vecs[v].en; src0_empty = vecs[v].e0; src1_empty = vecs[v].e1; pipe_full = vecs[v].full;
      src0_dout = 24'hA1B2C3; src1_dout = 24'h445566;
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("vec%0d_ctrl", v), {busy, src0_rd_en, src1_rd_en, pipe_wr_en},
          {vecs[v].busy, vecs[v].rd0, vecs[v].rd1, vecs[v].wr});
      chk($sformatf("vec%0d_din", v), pipe_din, vecs[v].din);
    end

    // Single frame from source 0
    do_reset();
    load(0, 8, 8'h30);
    run_until_fd(1, 100);
    run(3);
    chk("s1_pipe_writes", wr_cnt, 8);
    chk("s1_rd0_count", rd0_cnt, 8);
    chk("s1_snk1_writes", w1_cnt, 0);
    if (fdq.size() > 0) chk("s1_fd_src", fdq[0], 1'b0);
    chk("s1_busy_end", busy, 1'b0);
    cmp_sinks();

    // Both sources loaded: alternate grants with one bubble between frames
    do_reset();
    load(0, 16, 8'h00);
    load(1, 16, 8'h80);
    run_until_fd(4, 300);
    run(3);
    if (fdq.size() == 4) chk("s2_order", {fdq[0], fdq[1], fdq[2], fdq[3]}, 4'b0101);
    chk("s2_feed_span", last_x - first_x, 34);
    cmp_sinks();

    // Tag queue full holds off the third grant until the first frame completes
    do_reset();
    load(0, 24, 8'h40);
    hold_pipe = 1;
    run(40);
    chk("s3_fed_before_release", rd0_cnt, 16);
    chk("s3_busy_held", busy, 1'b1);
    hold_pipe = 0;
    released = 1;
    run_until_fd(3, 200);
    run(3);
    chk("s3_third_after_done", (rd_after > fd_first) && (fd_first >= 0), 1'b1);
    cmp_sinks();

    // Random back-pressure and source gaps
    do_reset();
    rnd = 1;
    load(0, 16, 8'h10);
    load(1, 16, 8'hC0);
    run_until_fd(4, 3000);
    rnd = 0;
    run(5);
    cmp_sinks();

    // Asynchronous reset in the middle of a frame
    do_reset();
    load(1, 8, 8'h60);
    for (int i = 0; i < 20 && rd1_cnt < 3; i++) cycle();
    chk("s5_in_count3", rd1_cnt, 3);
    drive_inputs();
    reset = 1'b0;
    #1;
    chk("s5_reset_ctrl", {src0_rd_en, src1_rd_en, pipe_wr_en, pipe_rd_en, snk0_wr_en, snk1_wr_en, frame_done, busy}, 8'h00);
    chk("s5_reset_data", {pipe_din, snk0_din, snk1_din}, 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    pq.delete();
    load(0, 8, 8'h70);
    run(2);
    chk("s5_regrant_src0", {r0, r1}, 2'b10);

    // Enable gating, then stalls in FEED
    do_reset();
    load(1, 8, 8'h90);
    enable = 1'b0;
    run(20);
    chk("s6_no_grant", rd1_cnt, 0);
    chk("s6_not_busy", busy, 1'b0);
    enable = 1'b1;
    run(2);
    chk("s6_feed_next", {r0, r1}, 2'b01);
    force_full = 1;
    run(5);
    chk("s6_stalled", rd1_cnt, 1);
`ifdef FRAME_SCHED_STATS_EN
    chk("s6_stall_cnt", stall_cnt, 32'd5);
`endif
    force_full = 0;
    run_until_fd(1, 100);
    run(2);
    if (fdq.size() > 0) chk("s6_fd_src", fdq[0], 1'b1);
`ifdef FRAME_SCHED_STATS_EN
    chk("s6_frames1_cnt", frames1_cnt, 16'd1);
    chk("s6_frames0_cnt", frames0_cnt, 16'd0);
    chk("s6_stall_final", stall_cnt, 32'd5);
`endif
    cmp_sinks();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
